// File: rtl/ritc_dac_pkg.sv
// ritc_dac_pkg: shared geometry of the RITC DAC serial chain plus the
// field bit-reverse helper. The loader and this receiver both import it,
// so the two sides always agree on chain length and field bit order.
package ritc_dac_pkg;

  localparam int RITC_DAC_BITS    = 12;                        // bits per DAC channel
  localparam int RITC_DACS        = 33;                        // channels in the chain
  localparam int RITC_NUM_BITS    = RITC_DAC_BITS * RITC_DACS; // 396 chain bits
  localparam int RITC_VDD_CHANNEL = 31;                        // channel mirrored on VDD
  localparam int RITC_CNT_W       = 9;                         // shift-counter width

  // Channel fields travel MSB-first on the wire, while the chain is filled
  // LSB-first, so each 12-bit field has to be reversed to get the value back.
  function automatic logic [RITC_DAC_BITS-1:0] ritc_bit_rev(
    input logic [RITC_DAC_BITS-1:0] v
  );
    logic [RITC_DAC_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < RITC_DAC_BITS; i++) begin
      r[i] = v[RITC_DAC_BITS-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/ritc_edge_sync.sv
// ritc_edge_sync: STAGES-deep synchronizer for one asynchronous level,
// followed by a rising-edge detector.
// Ports:
//   clk   system clock
//   rst_n asynchronous active-low reset
//   d     asynchronous input level
//   rise  one-cycle pulse when the synchronized level goes 0 -> 1
// A level held high for many cycles produces a single pulse only.
module ritc_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Synchronizer chain plus one extra copy used as the edge reference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        sync[i] <= sync[i-1];
      end
      prev <= sync[STAGES-1];
    end
  end

  assign rise = sync[STAGES-1] & ~prev;

endmodule

// File: rtl/ritc_dac_chain_receiver.sv
// ritc_dac_chain_receiver: responder for the RITC DAC serial chain.
// Samples DAC_DIN/DAC_CLOCK/DAC_LATCH, shifts a 396-bit chain on each
// serial-clock rising edge and, on a latch with exactly 396 shifts,
// transfers the chain into a holding register.
// Ports:
//   CLK, RST_N    system clock, asynchronous active-low reset
//   DAC_DIN       serial data (sampled at the same stage as DAC_CLOCK)
//   DAC_CLOCK     serial shift clock, rising edge shifts
//   DAC_LATCH     latch strobe, rising edge transfers
//   DAC_DOUT      registered chain[0], the bit falling out of the chain
//   rd_addr_i     channel index for readback (>= 33 reads 0)
//   rd_dat_o      unscrambled channel value, 1-cycle latency
//   clr_err_i     clears length_err_o (a new error in the same cycle wins)
//   frame_done_o  one-cycle pulse after an accepted latch
//   length_err_o  sticky: latch seen with a bit count other than 396
//   frame_cnt_o   accepted-frame counter, wraps
//   VDD           unscrambled VDD_CHANNEL field of the holding register
// Chain geometry comes from ritc_dac_pkg so it stays shared with the loader.
module ritc_dac_chain_receiver
  import ritc_dac_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int VDD_CHANNEL = RITC_VDD_CHANNEL
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     DAC_DIN,
  input  logic                     DAC_CLOCK,
  input  logic                     DAC_LATCH,
  output logic                     DAC_DOUT,
  input  logic [5:0]               rd_addr_i,
  output logic [RITC_DAC_BITS-1:0] rd_dat_o,
  input  logic                     clr_err_i,
  output logic                     frame_done_o,
  output logic                     length_err_o,
  output logic [15:0]              frame_cnt_o,
  output logic [RITC_DAC_BITS-1:0] VDD
);

  localparam logic [RITC_CNT_W-1:0] FULL_COUNT = RITC_CNT_W'(RITC_NUM_BITS);
  localparam logic [RITC_CNT_W-1:0] CNT_MAX    = '1;

  logic [SYNC_STAGES-1:0]   din_sync;
  logic                     clock_rise;
  logic                     latch_rise;
  logic [RITC_NUM_BITS-1:0] chain;
  logic [RITC_NUM_BITS-1:0] holding;
  logic [RITC_CNT_W-1:0]    bit_cnt;   // 0 means idle, >0 means mid-frame
  logic [RITC_NUM_BITS-1:0] chain_nx;
  logic [RITC_CNT_W-1:0]    cnt_nx;
  logic                     frame_ok;
  logic                     frame_bad;
  logic [RITC_DAC_BITS-1:0] fields [RITC_DACS];

  ritc_edge_sync #(.STAGES(SYNC_STAGES)) u_clock_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (DAC_CLOCK),
    .rise  (clock_rise)
  );

  ritc_edge_sync #(.STAGES(SYNC_STAGES)) u_latch_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (DAC_LATCH),
    .rise  (latch_rise)
  );

  // DIN synchronizer, same depth as CLOCK so data stays aligned with its edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      din_sync <= '0;
    end else begin
      din_sync[0] <= DAC_DIN;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        din_sync[i] <= din_sync[i-1];
      end
    end
  end

  // Post-shift chain and count; a latch in the same cycle sees these values.
  always_comb begin
    chain_nx = chain;
    cnt_nx   = bit_cnt;
    if (clock_rise) begin
      chain_nx = {din_sync[SYNC_STAGES-1], chain[RITC_NUM_BITS-1:1]};
      cnt_nx   = (bit_cnt == CNT_MAX) ? bit_cnt : bit_cnt + {{(RITC_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      chain_nx = chain;
      cnt_nx   = bit_cnt;
    end
    frame_ok  = latch_rise && (cnt_nx == FULL_COUNT);
    frame_bad = latch_rise && (cnt_nx != FULL_COUNT);
  end

  // Unscrambled view of every channel field in the holding register.
  always_comb begin
    for (int k = 0; k < RITC_DACS; k++) begin
      fields[k] = ritc_bit_rev(holding[k*RITC_DAC_BITS +: RITC_DAC_BITS]);
    end
  end

  // Chain and bit counter; the chain survives a latch so it can feed DOUT.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      chain   <= '0;
      bit_cnt <= '0;
    end else begin
      chain   <= chain_nx;
      bit_cnt <= latch_rise ? '0 : cnt_nx;
    end
  end

  // Holding register, loaded only by a full-length frame.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      holding <= '0;
    end else if (frame_ok) begin
      holding <= chain_nx;
    end
  end

  // Frame status: done pulse, frame counter and sticky length error.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      frame_done_o <= 1'b0;
      frame_cnt_o  <= 16'd0;
      length_err_o <= 1'b0;
    end else begin
      frame_done_o <= frame_ok;
      if (frame_ok) begin
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end
      if (frame_bad) begin
        length_err_o <= 1'b1;
      end else if (clr_err_i) begin
        length_err_o <= 1'b0;
      end
    end
  end

  // Registered data outputs: chain tail, channel readback and VDD mirror.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DAC_DOUT <= 1'b0;
      rd_dat_o <= '0;
      VDD      <= '0;
    end else begin
      DAC_DOUT <= chain[0];
      rd_dat_o <= (rd_addr_i < 6'(RITC_DACS)) ? fields[rd_addr_i] : '0;
      VDD      <= fields[VDD_CHANNEL];
    end
  end

endmodule

// File: tb/tb_ritc_dac_chain_receiver.sv
// Directed bench for ritc_dac_chain_receiver: drives the serial chain the
// way the DAC loader does and checks readback, status and DOUT loopback
// against hand-computed expectations.
module tb_ritc_dac_chain_receiver;
  import ritc_dac_pkg::*;

  localparam int NB = RITC_NUM_BITS;

  logic        CLK;
  logic        RST_N;
  logic        DAC_DIN;
  logic        DAC_CLOCK;
  logic        DAC_LATCH;
  logic        DAC_DOUT;
  logic [5:0]  rd_addr_i;
  logic [11:0] rd_dat_o;
  logic        clr_err_i;
  logic        frame_done_o;
  logic        length_err_o;
  logic [15:0] frame_cnt_o;
  logic [11:0] VDD;

  int n_tests = 0;
  int n_fail  = 0;

  logic [NB-1:0] frame_a;
  logic [NB-1:0] frame_b;
  logic [11:0]   rd_val;
  int            pulses;
  int            err_seen;
  int            mism;

  ritc_dac_chain_receiver dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .DAC_DIN      (DAC_DIN),
    .DAC_CLOCK    (DAC_CLOCK),
    .DAC_LATCH    (DAC_LATCH),
    .DAC_DOUT     (DAC_DOUT),
    .rd_addr_i    (rd_addr_i),
    .rd_dat_o     (rd_dat_o),
    .clr_err_i    (clr_err_i),
    .frame_done_o (frame_done_o),
    .length_err_o (length_err_o),
    .frame_cnt_o  (frame_cnt_o),
    .VDD          (VDD)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // One serial bit: data set with the clock rise, clock held high then low.
  task automatic send_bit(input logic b);
    DAC_DIN   = b;
    DAC_CLOCK = 1'b1;
    wait_cyc(4);
    DAC_CLOCK = 1'b0;
    wait_cyc(4);
  endtask

  // Sends n bits of f in transmit order (bit 0 first), wrapping past 396.
  task automatic send_frame(input logic [NB-1:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      send_bit(f[i % NB]);
    end
  endtask

  // Latch strobe; with_bit also raises the serial clock in the same cycle.
  task automatic do_latch(input bit with_bit, input logic b, output int pls, output int es);
    if (with_bit) begin
      DAC_DIN   = b;
      DAC_CLOCK = 1'b1;
    end
    DAC_LATCH = 1'b1;
    pls = 0;
    es  = 0;
    for (int i = 0; i < 10; i++) begin
      wait_cyc(1);
      if (frame_done_o) pls++;
      if (length_err_o) es = 1;
    end
    DAC_CLOCK = 1'b0;
    DAC_LATCH = 1'b0;
    wait_cyc(6);
  endtask

  task automatic read_ch(input logic [5:0] a, output logic [11:0] v);
    rd_addr_i = a;
    wait_cyc(2);
    v = rd_dat_o;
  endtask

  // Channel k carries base+k, each field bit-reversed so the wire is MSB-first.
  function automatic logic [NB-1:0] build(input logic [11:0] base);
    logic [NB-1:0] f;
    f = '0;
    for (int k = 0; k < RITC_DACS; k++) begin
      f[k*12 +: 12] = ritc_bit_rev(base + 12'(k));
    end
    return f;
  endfunction

  initial begin
    RST_N     = 1'b0;
    DAC_DIN   = 1'b0;
    DAC_CLOCK = 1'b0;
    DAC_LATCH = 1'b0;
    rd_addr_i = 6'd0;
    clr_err_i = 1'b0;
    frame_a   = build(12'h100);
    frame_b   = build(12'hA00);
    wait_cyc(3);

    // Reset state
    check("rst_dout", 32'(DAC_DOUT), 32'd0);
    check("rst_done", 32'(frame_done_o), 32'd0);
    check("rst_err", 32'(length_err_o), 32'd0);
    check("rst_fcnt", 32'(frame_cnt_o), 32'd0);
    check("rst_rd", 32'(rd_dat_o), 32'd0);
    check("rst_vdd", 32'(VDD), 32'd0);
    RST_N = 1'b1;
    wait_cyc(3);

    // Full frame A
    send_frame(frame_a, NB);
    do_latch(1'b0, 1'b0, pulses, err_seen);
    check("full_pulse", 32'(pulses), 32'd1);
    check("full_fcnt", 32'(frame_cnt_o), 32'd1);
    check("full_err", 32'(length_err_o), 32'd0);
    check("full_vdd", 32'(VDD), 32'h11F);
    read_ch(6'd5, rd_val);
    check("full_rd5", 32'(rd_val), 32'h105);
    read_ch(6'd0, rd_val);
    check("full_rd0", 32'(rd_val), 32'h100);
    read_ch(6'd32, rd_val);
    check("full_rd32", 32'(rd_val), 32'h120);

    // Short frame: 395 bits of B
    send_frame(frame_b, NB - 1);
    do_latch(1'b0, 1'b0, pulses, err_seen);
    check("short_pulse", 32'(pulses), 32'd0);
    check("short_err", 32'(length_err_o), 32'd1);
    check("short_fcnt", 32'(frame_cnt_o), 32'd1);
    read_ch(6'd5, rd_val);
    check("short_rd5", 32'(rd_val), 32'h105);
    check("short_vdd", 32'(VDD), 32'h11F);
    clr_err_i = 1'b1;
    wait_cyc(1);
    clr_err_i = 1'b0;
    wait_cyc(1);
    check("short_clr", 32'(length_err_o), 32'd0);

    // Long frame with clear held through the latch: the new error must win
    send_frame(frame_b, NB + 1);
    clr_err_i = 1'b1;
    do_latch(1'b0, 1'b0, pulses, err_seen);
    check("long_err_wins", 32'(err_seen), 32'd1);
    check("long_pulse", 32'(pulses), 32'd0);
    check("long_err_cleared", 32'(length_err_o), 32'd0);
    clr_err_i = 1'b0;
    check("long_fcnt", 32'(frame_cnt_o), 32'd1);

    // 908 = 512 + 396 shifts: a wrapping 9-bit counter would see 396 here
    send_frame(frame_b, 908);
    do_latch(1'b0, 1'b0, pulses, err_seen);
    check("sat_err", 32'(length_err_o), 32'd1);
    check("sat_pulse", 32'(pulses), 32'd0);
    check("sat_fcnt", 32'(frame_cnt_o), 32'd1);
    read_ch(6'd5, rd_val);
    check("sat_rd5", 32'(rd_val), 32'h105);
    clr_err_i = 1'b1;
    wait_cyc(1);
    clr_err_i = 1'b0;

    // DOUT loopback: frame A falls out while frame B shifts in
    send_frame(frame_a, NB);
    do_latch(1'b0, 1'b0, pulses, err_seen);
    check("loopA_fcnt", 32'(frame_cnt_o), 32'd2);
    mism = 0;
    for (int i = 0; i < NB; i++) begin
      if (DAC_DOUT !== frame_a[i]) mism++;
      send_bit(frame_b[i]);
    end
    check("loop_dout_mism", 32'(mism), 32'd0);
    do_latch(1'b0, 1'b0, pulses, err_seen);
    check("loopB_pulse", 32'(pulses), 32'd1);
    check("loopB_fcnt", 32'(frame_cnt_o), 32'd3);
    check("loopB_vdd", 32'(VDD), 32'hA1F);
    read_ch(6'd5, rd_val);
    check("loopB_rd5", 32'(rd_val), 32'hA05);

    // Last clock edge and latch edge in the same cycle
    send_frame(frame_a, NB - 1);
    do_latch(1'b1, frame_a[NB-1], pulses, err_seen);
    check("simul_pulse", 32'(pulses), 32'd1);
    check("simul_fcnt", 32'(frame_cnt_o), 32'd4);
    check("simul_err", 32'(length_err_o), 32'd0);
    read_ch(6'd5, rd_val);
    check("simul_rd5", 32'(rd_val), 32'h105);
    read_ch(6'd33, rd_val);
    check("rd33_zero", 32'(rd_val), 32'd0);
    read_ch(6'd63, rd_val);
    check("rd63_zero", 32'(rd_val), 32'd0);

    // Reset mid-frame, then a 196-bit remainder that must be rejected
    send_frame(frame_b, 200);
    RST_N = 1'b0;
    #2;
    check("midrst_fcnt", 32'(frame_cnt_o), 32'd0);
    check("midrst_vdd", 32'(VDD), 32'd0);
    wait_cyc(2);
    RST_N = 1'b1;
    wait_cyc(2);
    send_frame(frame_b, 196);
    do_latch(1'b0, 1'b0, pulses, err_seen);
    check("post_err", 32'(length_err_o), 32'd1);
    check("post_pulse", 32'(pulses), 32'd0);
    check("post_fcnt", 32'(frame_cnt_o), 32'd0);
    check("post_vdd", 32'(VDD), 32'd0);
    read_ch(6'd5, rd_val);
    check("post_rd5", 32'(rd_val), 32'd0);
    read_ch(6'd0, rd_val);
    check("post_rd0", 32'(rd_val), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
